// File: rtl/uart_term_line_echo_pkg.sv
// Shared types and helpers for the terminal line-echo front end:
// FSM states, echo sequence kinds and the echo sequence ROM.
`include "term_chars.vh"

package uart_term_line_echo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // What the latched character echoes back to the terminal.
    typedef enum logic [2:0] {
        EK_NONE = 3'd0,   // silently dropped
        EK_CHAR = 3'd1,   // the character itself
        EK_BEL  = 3'd2,   // error bell
        EK_BS   = 3'd3,   // rub-out: BS, SP, BS
        EK_CRLF = 3'd4    // line end: CR, LF
    } echo_kind_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= `PRINT_LO) && (c <= `PRINT_HI);
    endfunction

    // Number of bytes in the echo sequence for a kind (0..3).
    function automatic logic [1:0] seq_count(input echo_kind_t k);
        logic [1:0] n;
        case (k)
            EK_CHAR: n = 2'd1;
            EK_BEL:  n = 2'd1;
            EK_BS:   n = 2'd3;
            EK_CRLF: n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    // Echo sequence ROM: byte at position i of the sequence for kind k.
    function automatic logic [7:0] seq_byte(input echo_kind_t k,
                                            input logic [7:0] c,
                                            input logic [1:0] i);
        logic [7:0] b;
        case (k)
            EK_CHAR: b = c;
            EK_BEL:  b = `BEL;
            EK_BS:   b = (i == 2'd1) ? `SP : `BS;
            EK_CRLF: b = (i == 2'd0) ? `CR : `LF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/term_chars.vh
// Terminal character codes shared by the line-editing front end.
`ifndef TERM_CHARS_VH
`define TERM_CHARS_VH

`define BEL      8'h07
`define BS       8'h08
`define SP       8'h20
`define LF       8'h0A
`define CR       8'h0D
`define DEL      8'h7F
`define PRINT_LO 8'h20
`define PRINT_HI 8'h7E

`endif

// File: rtl/term_line_buf.sv
// Line storage: DEPTH x 8 memory, synchronous write, combinational read.
module term_line_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Store one character per write strobe; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_term_line_echo.sv
// Terminal line editor: pops bytes from the receive buffer, edits the
// current line (store / rub-out / terminate), echoes the visible effect
// to the transmit stage and announces completed lines.
`include "term_chars.vh"

module uart_term_line_echo
    import uart_term_line_echo_pkg::*;
#(
    parameter int LINE_MAX   = 64,
    parameter bit BEL_ON_ERR = 1'b1,
    localparam int W  = $clog2(LINE_MAX + 1),
    localparam int AW = $clog2(LINE_MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_empty,
    input  logic [7:0]    rx_data,
    output logic          rx_get,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          line_done,
    output logic [W-1:0]  line_len,
    input  logic [AW-1:0] line_raddr,
    output logic [7:0]    line_rdata
);

    localparam logic [W-1:0] LEN_MAX  = W'(LINE_MAX);
    localparam echo_kind_t   ERR_KIND = BEL_ON_ERR ? EK_BEL : EK_NONE;

    state_t       state;
    echo_kind_t   kind_q;
    logic [7:0]   ch_q;
    logic [1:0]   idx;
    logic [W-1:0] len;
    logic [W-1:0] done_len;
    logic         done_hold;

    echo_kind_t   cls_kind;
    logic         cls_store;
    logic         cls_dec;
    logic         buf_we;

    // Pop only when idle, so at most one received byte is ever in flight.
    always_comb begin
        rx_get = rst_n && (state == ST_IDLE) && !rx_empty;
    end

    // Classify the head byte against the current line length.
    always_comb begin
        cls_kind  = EK_NONE;
        cls_store = 1'b0;
        cls_dec   = 1'b0;
        if (is_printable(rx_data)) begin
            if (len < LEN_MAX) begin
                cls_kind  = EK_CHAR;
                cls_store = 1'b1;
            end else begin
                cls_kind = ERR_KIND;
            end
        end else if ((rx_data == `BS) || (rx_data == `DEL)) begin
            if (len != '0) begin
                cls_kind = EK_BS;
                cls_dec  = 1'b1;
            end else begin
                cls_kind = ERR_KIND;
            end
        end else if (rx_data == `CR) begin
            cls_kind = EK_CRLF;
        end
    end

    assign buf_we = rx_get && cls_store;

    // Keep the character for the echo ROM while the sequence is emitted.
    always_ff @(posedge clk) begin
        if (rx_get) begin
            ch_q <= rx_data;
        end
    end

    // Control FSM: pop/classify, emit echo sequence, finish the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            kind_q    <= EK_NONE;
            idx       <= 2'd0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            line_done <= 1'b0;
            len       <= '0;
            done_len  <= '0;
            done_hold <= 1'b0;
        end else begin
            line_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_get) begin
                        kind_q <= cls_kind;
                        idx    <= 2'd0;
                        if (cls_store) begin
                            len       <= len + W'(1);
                            done_hold <= 1'b0;
                        end else if (cls_dec) begin
                            len <= len - W'(1);
                        end
                        if (seq_count(cls_kind) != 2'd0) begin
                            tx_valid <= 1'b1;
                            tx_data  <= seq_byte(cls_kind, rx_data, 2'd0);
                            state    <= ST_EMIT;
                        end else begin
                            state <= ST_FIN;
                        end
                    end
                end
                ST_EMIT: begin
                    if (tx_ready) begin
                        if (idx == seq_count(kind_q) - 2'd1) begin
                            tx_valid <= 1'b0;
                            state    <= ST_FIN;
                            if (kind_q == EK_CRLF) begin
                                // Expose the live length during the done pulse.
                                line_done <= 1'b1;
                                done_hold <= 1'b0;
                            end
                        end else begin
                            idx     <= idx + 2'd1;
                            tx_data <= seq_byte(kind_q, ch_q, idx + 2'd1);
                        end
                    end
                end
                ST_FIN: begin
                    if (kind_q == EK_CRLF) begin
                        done_hold <= 1'b1;
                        done_len  <= len;
                        len       <= '0;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign line_len = done_hold ? done_len : len;

    term_line_buf #(
        .DEPTH (LINE_MAX),
        .AW    (AW)
    ) u_line_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (len[AW-1:0]),
        .wdata (rx_data),
        .raddr (line_raddr),
        .rdata (line_rdata)
    );

endmodule

// File: doc/uart_term_line_echo.md
Name: uart_term_line_echo

Overview:
Terminal front-end stage downstream of the UART receive ring buffer. Pops received bytes through the buffer's get/data/empty interface and performs line editing. Echoes the edited result as a byte stream to a downstream UART transmit stage over a valid/ready handshake. Completed lines are held in a local line buffer and announced to the application with a one-cycle done pulse and a length.

Parameters:
LINE_MAX, 64, maximum stored characters per line; must be 2..256.
BEL_ON_ERR, 1, when 1, overflow and backspace-at-empty echo BEL (0x07); when 0, they echo nothing.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
rx_empty  input  1  receive buffer empty flag.
rx_data  input  8  head byte of receive buffer; valid whenever rx_empty=0.
rx_get  output  1  pop strobe; head consumed on the clk edge where rx_get=1.
tx_data  output  8  echo byte to transmit stage.
tx_valid  output  1  tx_data valid; held stable until accepted.
tx_ready  input  1  transmit stage accepts on an edge where tx_valid=1 and tx_ready=1.
line_done  output  1  one-cycle pulse: line terminated by CR.
line_len  output  W  W=clog2(LINE_MAX+1); current line length, and completed length while done-hold is set.
line_raddr  input  clog2(LINE_MAX)  line buffer read address.
line_rdata  output  8  combinational read of line buffer at line_raddr.

Behaviour:
- Reset (async, rst_n=0): state IDLE; rx_get=0, tx_valid=0, tx_data=0x00, line_done=0, line_len=0; done-hold cleared. Line buffer contents are not reset.
- Reset mid-sequence: the pending echo sequence is abandoned. tx_valid drops immediately. The partial line is discarded.
- FSM states: IDLE, EMIT, FIN.
- IDLE: rx_get = !rx_empty (combinational, only in IDLE). On a pop edge, latch rx_data into char reg and go to EMIT. rx_get is never asserted outside IDLE, so at most one byte is in flight.
- Classification of the latched char (decided on entry to EMIT):
  - Printable 0x20..0x7E with len<LINE_MAX: write buf[len]; len+1; echo [char].
  - Printable with len==LINE_MAX: not stored; echo [0x07] if BEL_ON_ERR, else nothing.
  - 0x08 or 0x7F with len>0: len-1; echo [0x08,0x20,0x08].
  - 0x08 or 0x7F with len==0: echo [0x07] if BEL_ON_ERR, else nothing.
  - 0x0D: echo [0x0D,0x0A]; line completion in FIN.
  - 0x0A and all other controls: dropped; no echo; len unchanged.
- EMIT: presents the sequence index 0..2. tx_valid=1, tx_data=seq[idx]. Index advances on each accepted edge, so back-to-back bytes are possible with no bubble. After the last acceptance go to FIN. An empty sequence goes straight to FIN.
- FIN (1 cycle):
  - If the char was CR: line_done=1, line_len=len (pre-clear), set done-hold; then len <= 0.
  - Return to IDLE.
- Done-hold:
  - While set, line_len reports the completed length and the buffer is readable unchanged.
  - Cleared by the next stored printable char, which overwrites buf[0].
  - Backspace while held: no-op with BEL (len=0 rule applies).
- Latency:
  - Pop at edge N.
  - First tx_valid in cycle N+1.
  - Earliest next rx_get: cycle after FIN, i.e. 2 cycles after last acceptance.
- tx_data/tx_valid must not change while tx_valid=1 and tx_ready=0.
- len arithmetic is W bits wide and never wraps; bounds are checked before increment/decrement.

Decomposition:
- Shared include term_chars.vh: `define constants for BEL 0x07, BS 0x08, SP 0x20, LF 0x0A, CR 0x0D, DEL 0x7F, PRINT_LO 0x20, PRINT_HI 0x7E.
- One sub-module, term_line_buf: LINE_MAX x 8 memory with a synchronous write port (we, waddr, wdata) and a combinational read port. It maps to iCE40 logic/BRAM.
- The FSM, sequence ROM and len counter stay in uart_term_line_echo.

Test Plan:
- rx bytes 'h','i',0x0D with tx_ready tied 1:
  - tx stream 0x68,0x69,0x0D,0x0A.
  - line_done pulses once with line_len=2.
  - line_raddr 0/1 -> 0x68/0x69.
- 'a',0x7F,'b',0x0D -> tx 0x61,0x08,0x20,0x08,0x62,0x0D,0x0A; line_len=1; buf[0]=0x62.
- LINE_MAX=4, send 'abcde',0x0D:
  - tx 'abcd',0x07,0x0D,0x0A.
  - line_len=4.
  - BEL_ON_ERR=0 variant omits 0x07.
- 0x08 at empty line, then 0x0A, then 0x01 -> tx 0x07 only; no rx byte echoed for 0x0A/0x01; line_len stays 0.
- tx_ready toggled randomly (e.g. 1 of 3 cycles) during "ok\r":
  - tx_data stable while stalled.
  - Same byte order as the ready=1 case.
  - rx_get never asserted while tx_valid=1.
- Assert rst_n low mid-sequence (after 0x08 sent of a backspace triple):
  - tx_valid=0 immediately; line_len=0.
  - After release, 'x' echoes 0x78 with line_len=1.
